// File: rtl/adar7251_pkg.sv
// ---------------------------------------------------------------------------
// adar7251_pkg
//
// Purpose : Shared types and constants for the ADAR7251 SPI init sequencer.
//           - seq_state_t : sequencer FSM states
//           - rom_entry_t : one {addr, data} register write
//           - ADAR7251 register addresses and the default power-up values
//           - HOST_ERR_INDEX : error index reported when a host access faults
//           - default_rom_entry() : index -> default init write
//
// Configuration macro: ADAR_READBACK_VERIFY_EN (consumed by the sequencer top;
// the VERIFY_* states exist here in every build but are reachable only when it
// is defined).
// ---------------------------------------------------------------------------
package adar7251_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_VERIFY_ISSUE,
        ST_VERIFY_WAIT,
        ST_NEXT,
        ST_READY,
        ST_HOST_ISSUE,
        ST_HOST_WAIT,
        ST_FAULT
    } seq_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } rom_entry_t;

    // Reported in o_err_index when the faulting access belonged to the host.
    localparam logic [5:0] HOST_ERR_INDEX = 6'd63;

    // ADAR7251 register map (subset touched during bring-up).
    localparam logic [15:0] ADAR_REG_CLK_CTRL      = 16'h0000;
    localparam logic [15:0] ADAR_REG_PLL_DEN       = 16'h0001;
    localparam logic [15:0] ADAR_REG_PLL_NUM       = 16'h0002;
    localparam logic [15:0] ADAR_REG_PLL_CTRL      = 16'h0003;
    localparam logic [15:0] ADAR_REG_MASTER_ENABLE = 16'h0040;
    localparam logic [15:0] ADAR_REG_ADC_ENABLE    = 16'h0041;
    localparam logic [15:0] ADAR_REG_LNA_GAIN      = 16'h0100;
    localparam logic [15:0] ADAR_REG_OUTPUT_MODE   = 16'h01C2;

    // Default power-up values, written in the order listed below.
    localparam logic [15:0] ADAR_VAL_CLK_CTRL      = 16'h0001;
    localparam logic [15:0] ADAR_VAL_PLL_DEN       = 16'h0019;
    localparam logic [15:0] ADAR_VAL_PLL_NUM       = 16'h0007;
    localparam logic [15:0] ADAR_VAL_PLL_CTRL      = 16'h2101;
    localparam logic [15:0] ADAR_VAL_MASTER_ENABLE = 16'h0001;
    localparam logic [15:0] ADAR_VAL_ADC_ENABLE    = 16'h000F;
    localparam logic [15:0] ADAR_VAL_LNA_GAIN      = 16'h0055;
    localparam logic [15:0] ADAR_VAL_OUTPUT_MODE   = 16'h0004;

    // Clock and PLL are programmed before anything is enabled; the ADCs are
    // switched on only once the master enable is set.
    function automatic rom_entry_t default_rom_entry(input logic [5:0] idx);
        rom_entry_t e;
        e = '0;
        unique case (idx)
            6'd0:    e = '{addr: ADAR_REG_CLK_CTRL,      data: ADAR_VAL_CLK_CTRL};
            6'd1:    e = '{addr: ADAR_REG_PLL_DEN,       data: ADAR_VAL_PLL_DEN};
            6'd2:    e = '{addr: ADAR_REG_PLL_NUM,       data: ADAR_VAL_PLL_NUM};
            6'd3:    e = '{addr: ADAR_REG_PLL_CTRL,      data: ADAR_VAL_PLL_CTRL};
            6'd4:    e = '{addr: ADAR_REG_MASTER_ENABLE, data: ADAR_VAL_MASTER_ENABLE};
            6'd5:    e = '{addr: ADAR_REG_ADC_ENABLE,    data: ADAR_VAL_ADC_ENABLE};
            6'd6:    e = '{addr: ADAR_REG_LNA_GAIN,      data: ADAR_VAL_LNA_GAIN};
            6'd7:    e = '{addr: ADAR_REG_OUTPUT_MODE,   data: ADAR_VAL_OUTPUT_MODE};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/adar7251_init_rom.sv
// ---------------------------------------------------------------------------
// adar7251_init_rom
//
// Purpose : Combinational init ROM. Maps an entry index to the {addr, data}
//           register write performed at that step of the init sequence.
//           Indices at or beyond NUM_REGS read as zero.
//
// Parameters:
//   NUM_REGS  number of valid entries (1..64)
//
// Ports:
//   index  in   6            entry index
//   entry  out  rom_entry_t  {addr[15:0], data[15:0]} for that index
// ---------------------------------------------------------------------------
module adar7251_init_rom
    import adar7251_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [5:0] index,
    output rom_entry_t entry
);

    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves it unassigned would otherwise infer a latch.
    always_comb begin
        entry = '0;
        if (32'(index) < 32'(NUM_REGS)) begin
            entry = default_rom_entry(index);
        end
    end

endmodule

// File: rtl/adar7251_init_sequencer.sv
// ---------------------------------------------------------------------------
// adar7251_init_sequencer
//
// Purpose : Sole driver of the SPI_ADAR7251_40bit register master. After
//           i_start it waits PWR_WAIT_CYC cycles, walks the init ROM issuing
//           one register write per entry, then hands the SPI master to a
//           single host register-access port. Every SPI access is guarded by
//           a TIMEOUT_CYC watchdog; an expired access parks the block in
//           FAULT until i_start or reset.
//
// Configuration macro:
//   ADAR_READBACK_VERIFY_EN  when defined, each init write is followed by a
//                            read of the same address; a readback differing
//                            from the ROM data is a fault. When undefined no
//                            readback or compare logic exists.
//
// Parameters:
//   NUM_REGS      number of ROM init entries (1..64)
//   PWR_WAIT_CYC  cycles waited after i_start before the first access (>=1)
//   TIMEOUT_CYC   max cycles from o_spi_enable to i_spi_finish (>=1)
//
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_start                    pulse: (re)run the init sequence
//   i_host_req                 level: host access request, held until ack
//   i_host_rd_wrb              1 = read, 0 = write
//   i_host_addr, i_host_data   host register address / write data
//   o_host_ack                 1-cycle pulse: host access complete
//   o_host_rdata               read data, valid with o_host_ack, then held
//   o_spi_enable               1-cycle start pulse to the SPI core
//   o_spi_rd_wrb, o_spi_addr,
//   o_spi_data                 access descriptor to the SPI core
//   i_spi_rdata, i_spi_busy,
//   i_spi_finish               read data / busy / done pulse from the SPI core
//   o_init_done                level: init completed without error
//   o_error                    level: sequencer in FAULT
//   o_err_index                ROM index at fault (63 = host access)
// ---------------------------------------------------------------------------
module adar7251_init_sequencer
    import adar7251_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int PWR_WAIT_CYC = 100,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_host_req,
    input  logic        i_host_rd_wrb,
    input  logic [15:0] i_host_addr,
    input  logic [15:0] i_host_data,
    output logic        o_host_ack,
    output logic [15:0] o_host_rdata,
    output logic        o_spi_enable,
    output logic        o_spi_rd_wrb,
    output logic [15:0] o_spi_addr,
    output logic [15:0] o_spi_data,
    input  logic [15:0] i_spi_rdata,
    input  logic        i_spi_busy,
    input  logic        i_spi_finish,
    output logic        o_init_done,
    output logic        o_error,
    output logic [5:0]  o_err_index
);

    // One counter serves both the power-up wait and the access watchdog; the
    // two are never active at the same time.
    localparam int CNT_MAX = (PWR_WAIT_CYC > TIMEOUT_CYC) ? PWR_WAIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST     = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]       LAST_INDEX   = 6'(NUM_REGS - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       index_q;
    rom_entry_t       rom_entry;

    logic             host_rd_q;
    logic [15:0]      host_addr_q;
    logic [15:0]      host_data_q;
    logic             ack_q;
    logic [15:0]      rdata_q;
    logic             init_done_q;
    logic             error_q;
    logic [5:0]       err_index_q;

    logic             timeout_hit;
    logic             counting;
    logic             host_fault;

    adar7251_init_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .index (index_q),
        .entry (rom_entry)
    );

    // The counter is cleared on every state change, so in a WAIT state it
    // counts cycles since the enable pulse that left the ISSUE state.
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        counting = 1'b0;
        unique case (state_q)
            ST_PWR_WAIT, ST_INIT_WAIT, ST_VERIFY_WAIT, ST_HOST_WAIT: counting = 1'b1;
            default:                                                  counting = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_PWR_WAIT;
            end
            ST_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) state_d = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: begin
                if (!i_spi_busy) state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (i_spi_finish) begin
`ifdef ADAR_READBACK_VERIFY_EN
                    state_d = ST_VERIFY_ISSUE;
`else
                    state_d = ST_NEXT;
`endif
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                end
            end
`ifdef ADAR_READBACK_VERIFY_EN
            ST_VERIFY_ISSUE: begin
                if (!i_spi_busy) state_d = ST_VERIFY_WAIT;
            end
            ST_VERIFY_WAIT: begin
                if (i_spi_finish) begin
                    state_d = (i_spi_rdata != rom_entry.data) ? ST_FAULT : ST_NEXT;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                end
            end
`endif
            ST_NEXT: begin
                state_d = (index_q == LAST_INDEX) ? ST_READY : ST_INIT_ISSUE;
            end
            ST_READY: begin
                // i_start outranks a simultaneous host request; the host
                // simply stays pending. While the ack pulse is out the
                // request is still the one just served, so it is not retaken.
                if (i_start) begin
                    state_d = ST_PWR_WAIT;
                end else if (i_host_req && !ack_q) begin
                    state_d = ST_HOST_ISSUE;
                end
            end
            ST_HOST_ISSUE: begin
                if (!i_spi_busy) state_d = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                if (i_spi_finish) begin
                    state_d = ST_READY;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (i_start) state_d = ST_PWR_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: SPI-side outputs decoded from the current state.
    // The enable is gated by i_spi_busy so an ISSUE state stalls without
    // pulsing; leaving ISSUE on the same condition keeps it to one cycle.
    // The descriptor comes from index_q / latched host fields, which only
    // change outside the ISSUE/WAIT states, so it holds until finish.
    // -----------------------------------------------------------------------
    always_comb begin
        o_spi_enable = 1'b0;
        o_spi_rd_wrb = 1'b0;
        o_spi_addr   = '0;
        o_spi_data   = '0;
        unique case (state_q)
            ST_INIT_ISSUE, ST_INIT_WAIT: begin
                o_spi_enable = (state_q == ST_INIT_ISSUE) && !i_spi_busy;
                o_spi_addr   = rom_entry.addr;
                o_spi_data   = rom_entry.data;
            end
`ifdef ADAR_READBACK_VERIFY_EN
            ST_VERIFY_ISSUE, ST_VERIFY_WAIT: begin
                o_spi_enable = (state_q == ST_VERIFY_ISSUE) && !i_spi_busy;
                o_spi_rd_wrb = 1'b1;
                o_spi_addr   = rom_entry.addr;
            end
`endif
            ST_HOST_ISSUE, ST_HOST_WAIT: begin
                o_spi_enable = (state_q == ST_HOST_ISSUE) && !i_spi_busy;
                o_spi_rd_wrb = host_rd_q;
                o_spi_addr   = host_addr_q;
                o_spi_data   = host_data_q;
            end
            default: begin
                o_spi_enable = 1'b0;
            end
        endcase
    end

    assign host_fault = (state_q == ST_HOST_WAIT);

    // -----------------------------------------------------------------------
    // Datapath and status registers, updated on FSM transitions.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q       <= '0;
            index_q     <= '0;
            host_rd_q   <= 1'b0;
            host_addr_q <= '0;
            host_data_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            ack_q <= 1'b0;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (counting) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // (Re)start: any entry into PWR_WAIT begins a fresh sequence.
            if (state_d == ST_PWR_WAIT && state_q != ST_PWR_WAIT) begin
                index_q     <= '0;
                init_done_q <= 1'b0;
                error_q     <= 1'b0;
                err_index_q <= '0;
            end

            if (state_q == ST_NEXT) begin
                if (state_d == ST_READY) begin
                    init_done_q <= 1'b1;
                end else begin
                    index_q <= index_q + 6'd1;
                end
            end

            // Host fields are captured on acceptance so the SPI descriptor
            // cannot move even if the host changes its inputs mid-access.
            if (state_q == ST_READY && state_d == ST_HOST_ISSUE) begin
                host_rd_q   <= i_host_rd_wrb;
                host_addr_q <= i_host_addr;
                host_data_q <= i_host_data;
            end

            if (state_q == ST_HOST_WAIT && i_spi_finish) begin
                ack_q <= 1'b1;
                if (host_rd_q) rdata_q <= i_spi_rdata;
            end

            if (state_d == ST_FAULT && state_q != ST_FAULT) begin
                error_q     <= 1'b1;
                err_index_q <= host_fault ? HOST_ERR_INDEX : index_q;
            end
        end
    end

    assign o_host_ack   = ack_q;
    assign o_host_rdata = rdata_q;
    assign o_init_done  = init_done_q;
    assign o_error      = error_q;
    assign o_err_index  = err_index_q;

endmodule

// File: tb/tb_adar7251_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adar7251_init_sequencer
//
// Self-checking bench. A behavioural SPI core answers each o_spi_enable with
// 1..40 busy cycles and a finish pulse. Expected SPI accesses and host acks
// are pushed to scoreboard queues when stimulus is driven and popped when the
// DUT produces them. Define ADAR_READBACK_VERIFY_EN for both bench and RTL to
// exercise the readback build.
// ---------------------------------------------------------------------------
module tb_adar7251_init_sequencer;

    localparam int NUM_REGS     = 8;
    localparam int PWR_WAIT_CYC = 100;
    localparam int TIMEOUT_CYC  = 1023;

    // Independent copy of the expected power-up write list.
    localparam logic [15:0] ROM_ADDR [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                             16'h0040, 16'h0041, 16'h0100, 16'h01C2};
    localparam logic [15:0] ROM_DATA [8] = '{16'h0001, 16'h0019, 16'h0007, 16'h2101,
                                             16'h0001, 16'h000F, 16'h0055, 16'h0004};

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic        rd;
        logic [15:0] rdata;
    } ack_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_host_req;
    logic        i_host_rd_wrb;
    logic [15:0] i_host_addr;
    logic [15:0] i_host_data;
    logic        o_host_ack;
    logic [15:0] o_host_rdata;
    logic        o_spi_enable;
    logic        o_spi_rd_wrb;
    logic [15:0] o_spi_addr;
    logic [15:0] o_spi_data;
    logic [15:0] i_spi_rdata;
    logic        i_spi_busy;
    logic        i_spi_finish;
    logic        o_init_done;
    logic        o_error;
    logic [5:0]  o_err_index;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ack_count    = 0;

    acc_t exp_q[$];
    ack_t ack_exp_q[$];

    // SPI model controls
    bit          hang_en     = 0;
    logic [15:0] hang_addr   = 16'h0;
    int          hang_cyc    = 0;
    bit          force_en    = 0;
    logic [15:0] force_val   = 16'h0;
    bit          corrupt_en  = 0;
    logic [15:0] corrupt_addr = 16'h0;
    logic [15:0] mem [logic [15:0]];

    adar7251_init_sequencer #(
        .NUM_REGS     (NUM_REGS),
        .PWR_WAIT_CYC (PWR_WAIT_CYC),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_host_req    (i_host_req),
        .i_host_rd_wrb (i_host_rd_wrb),
        .i_host_addr   (i_host_addr),
        .i_host_data   (i_host_data),
        .o_host_ack    (o_host_ack),
        .o_host_rdata  (o_host_rdata),
        .o_spi_enable  (o_spi_enable),
        .o_spi_rd_wrb  (o_spi_rd_wrb),
        .o_spi_addr    (o_spi_addr),
        .o_spi_data    (o_spi_data),
        .i_spi_rdata   (i_spi_rdata),
        .i_spi_busy    (i_spi_busy),
        .i_spi_finish  (i_spi_finish),
        .o_init_done   (o_init_done),
        .o_error       (o_error),
        .o_err_index   (o_err_index)
    );

    always #5 clk = ~clk;

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Behavioural SPI core + access scoreboard
    // ------------------------------------------------------------------
    initial begin : spi_model
        logic        rd;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] rv;
        int          n;
        int          k;
        bit          hang;
        acc_t        e;
        i_spi_busy   = 1'b0;
        i_spi_finish = 1'b0;
        i_spi_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            if (o_spi_enable === 1'b1 && i_reset === 1'b0) begin
                rd = o_spi_rd_wrb;
                a  = o_spi_addr;
                d  = o_spi_data;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL spi_access: got rd=%0b addr=%h data=%h, required no access", rd, a, d);
                end else begin
                    e = exp_q.pop_front();
                    if (rd !== e.rd || a !== e.addr || (!e.rd && d !== e.data)) begin
                        tests_failed++;
                        $display("FAIL spi_access: got rd=%0b addr=%h data=%h, required rd=%0b addr=%h data=%h",
                                 rd, a, d, e.rd, e.addr, e.data);
                    end
                end
                n    = int'($urandom_range(40, 1));
                hang = hang_en && !rd && (a == hang_addr);
                if (hang) hang_cyc = cyc;
                @(posedge clk);
                #1;
                i_spi_busy = 1'b1;
                k = 0;
                while ((k < n || (hang && hang_en)) && i_reset !== 1'b1) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                if (hang || i_reset === 1'b1) begin
                    i_spi_busy = 1'b0;
                end else begin
                    tests_run++;
                    if (o_spi_rd_wrb !== rd || o_spi_addr !== a || (!rd && o_spi_data !== d)) begin
                        tests_failed++;
                        $display("FAIL spi_stable: got rd=%0b addr=%h data=%h before finish, required rd=%0b addr=%h data=%h",
                                 o_spi_rd_wrb, o_spi_addr, o_spi_data, rd, a, d);
                    end
                    if (rd) begin
                        rv = mem.exists(a) ? mem[a] : 16'h0;
                        if (corrupt_en && a == corrupt_addr) rv = rv ^ 16'h0100;
                        if (force_en) rv = force_val;
                        i_spi_rdata = rv;
                    end else begin
                        mem[a] = d;
                    end
                    i_spi_busy   = 1'b0;
                    i_spi_finish = 1'b1;
                    @(posedge clk);
                    #1;
                    i_spi_finish = 1'b0;
                end
            end
        end
    end

    // Host acknowledge scoreboard
    initial begin : ack_monitor
        ack_t e;
        forever begin
            @(negedge clk);
            if (o_host_ack === 1'b1) begin
                ack_count++;
                tests_run++;
                if (ack_exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL host_ack: got an ack with rdata=%h, required no ack", o_host_rdata);
                end else begin
                    e = ack_exp_q.pop_front();
                    if (e.rd && o_host_rdata !== e.rdata) begin
                        tests_failed++;
                        $display("FAIL host_rdata: got %h, required %h", o_host_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic push_init(input int upto, input bit last_read);
        for (int i = 0; i <= upto; i++) begin
            exp_q.push_back('{rd: 1'b0, addr: ROM_ADDR[i], data: ROM_DATA[i]});
`ifdef ADAR_READBACK_VERIFY_EN
            if (i < upto || last_read) exp_q.push_back('{rd: 1'b1, addr: ROM_ADDR[i], data: 16'h0});
`endif
        end
    endtask

    task automatic push_host(input logic rd, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] rdata);
        exp_q.push_back('{rd: rd, addr: a, data: d});
        ack_exp_q.push_back('{rd: rd, rdata: rdata});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_init_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (o_init_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok || o_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got init_done=%0b error=%0b, required init_done=1 error=0", name, o_init_done, o_error);
        end
    endtask

    task automatic wait_ack(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (o_host_ack === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s: got no host ack within 4000 cycles, required one", name);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (5) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0 || ack_exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: got %0d accesses and %0d acks outstanding, required 0 and 0",
                     name, exp_q.size(), ack_exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [58:0] outs;
        outs = {o_host_ack, o_host_rdata, o_spi_enable, o_spi_rd_wrb, o_spi_addr,
                o_spi_data, o_init_done, o_error, o_err_index};
        tests_run++;
        if (outs !== 59'd0) begin
            tests_failed++;
            $display("FAIL %s: got outputs %h, required all zero", name, outs);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        i_host_req = 1'b0;
        i_host_rd_wrb = 1'b0;
        i_host_addr = 16'h0;
        i_host_data = 16'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_outputs");
    endtask

    task automatic test_init();
        int k = 0;
        push_init(NUM_REGS - 1, 1'b1);
        @(negedge clk);
        i_start = 1'b1;
        // PWR_WAIT_CYC waiting cycles follow the edge that samples i_start;
        // the first enable appears in the cycle after them.
        do begin
            @(negedge clk);
            i_start = 1'b0;
            k++;
        end while (o_spi_enable !== 1'b1 && k < 300);
        tests_run++;
        if (k != PWR_WAIT_CYC + 1) begin
            tests_failed++;
            $display("FAIL pwr_wait: got first enable %0d cycles after start, required %0d", k, PWR_WAIT_CYC + 1);
        end
        wait_init_done("init_done");
        check_drained("init_sequence");
    endtask

    task automatic test_host_write();
        bit ok;
        int base = ack_count;
        push_host(1'b0, 16'h0505, 16'hAAAA, 16'h0);
        @(negedge clk);
        i_host_req = 1'b1;
        i_host_rd_wrb = 1'b0;
        i_host_addr = 16'h0505;
        i_host_data = 16'hAAAA;
        @(negedge clk);
        tests_run++;
        if (o_spi_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL host_enable_latency: got enable=%0b one cycle after request, required 1", o_spi_enable);
        end
        wait_ack("host_write_ack", ok);
        i_host_req = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (ack_count != base + 1) begin
            tests_failed++;
            $display("FAIL host_write_ack_count: got %0d acks, required 1", ack_count - base);
        end
        check_drained("host_write");
    endtask

    task automatic test_host_read();
        bit ok;
        force_en = 1;
        force_val = 16'h1234;
        push_host(1'b1, 16'h0505, 16'h0, 16'h1234);
        @(negedge clk);
        i_host_req = 1'b1;
        i_host_rd_wrb = 1'b1;
        i_host_addr = 16'h0505;
        wait_ack("host_read_ack", ok);
        i_host_req = 1'b0;
        force_en = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_host_rdata !== 16'h1234) begin
            tests_failed++;
            $display("FAIL host_rdata_hold: got %h after ack, required 1234", o_host_rdata);
        end
        check_drained("host_read");
    endtask

    task automatic test_timeout();
        bit ok = 0;
        int delta;
        hang_en = 1;
        hang_addr = ROM_ADDR[3];
        push_init(3, 1'b0);
        pulse_start();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (o_error === 1'b1) begin
                ok = 1;
                break;
            end
        end
        delta = cyc - hang_cyc;
        tests_run++;
        if (!ok || o_err_index !== 6'd3 || o_init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fault: got error=%0b err_index=%0d init_done=%0b, required 1 3 0",
                     o_error, o_err_index, o_init_done);
        end
        tests_run++;
        if (delta < TIMEOUT_CYC || delta > TIMEOUT_CYC + 2) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got fault %0d cycles after enable, required %0d..%0d",
                     delta, TIMEOUT_CYC, TIMEOUT_CYC + 2);
        end
        // FAULT must hold until restarted.
        repeat (20) @(negedge clk);
        tests_run++;
        if (o_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_hold: got error=%0b, required 1", o_error);
        end
        hang_en = 0;
        push_init(NUM_REGS - 1, 1'b1);
        pulse_start();
        tests_run++;
        if (o_error !== 1'b0 || o_init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_clear: got error=%0b init_done=%0b, required 0 0", o_error, o_init_done);
        end
        wait_init_done("restart_init_done");
        check_drained("restart_sequence");
    endtask

    task automatic test_host_pending();
        bit ok;
        push_init(NUM_REGS - 1, 1'b1);
        pulse_start();
        repeat (PWR_WAIT_CYC + 5) @(negedge clk);
        tests_run++;
        if (o_init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL pending_setup: got init_done=%0b while init running, required 0", o_init_done);
        end
        push_host(1'b0, 16'h0300, 16'h5A5A, 16'h0);
        i_host_req = 1'b1;
        i_host_rd_wrb = 1'b0;
        i_host_addr = 16'h0300;
        i_host_data = 16'h5A5A;
        wait_ack("pending_ack", ok);
        tests_run++;
        if (o_init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending_order: got init_done=%0b at ack, required 1", o_init_done);
        end
        i_host_req = 1'b0;
        check_drained("host_pending");
    endtask

    task automatic test_start_vs_host();
        bit ok;
        push_init(NUM_REGS - 1, 1'b1);
        push_host(1'b0, 16'h0200, 16'h0F0F, 16'h0);
        @(negedge clk);
        i_start = 1'b1;
        i_host_req = 1'b1;
        i_host_rd_wrb = 1'b0;
        i_host_addr = 16'h0200;
        i_host_data = 16'h0F0F;
        @(negedge clk);
        i_start = 1'b0;
        tests_run++;
        if (o_init_done !== 1'b0 || o_spi_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_priority: got init_done=%0b enable=%0b, required 0 0", o_init_done, o_spi_enable);
        end
        wait_ack("start_vs_host_ack", ok);
        tests_run++;
        if (o_init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_vs_host_order: got init_done=%0b at ack, required 1", o_init_done);
        end
        i_host_req = 1'b0;
        check_drained("start_vs_host");
    endtask

`ifdef ADAR_READBACK_VERIFY_EN
    task automatic test_verify_fault();
        bit ok = 0;
        corrupt_en = 1;
        corrupt_addr = ROM_ADDR[5];
        push_init(5, 1'b1);
        pulse_start();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (o_error === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok || o_err_index !== 6'd5) begin
            tests_failed++;
            $display("FAIL verify_fault: got error=%0b err_index=%0d, required 1 5", o_error, o_err_index);
        end
        corrupt_en = 0;
        check_drained("verify_sequence");
    endtask
`endif

    task automatic test_reset_mid_transfer();
        bit ok = 0;
        push_init(NUM_REGS - 1, 1'b1);
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i_spi_busy === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL mid_reset_setup: got no SPI access within 400 cycles, required one");
        end
        i_reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_transfer_reset");
        exp_q.delete();
        ack_exp_q.delete();
        @(negedge clk);
        i_reset = 1'b0;
        repeat (50) @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    initial begin
        test_reset();
        test_init();
        test_host_write();
        test_host_read();
        test_timeout();
        test_host_pending();
        test_start_vs_host();
`ifdef ADAR_READBACK_VERIFY_EN
        test_verify_fault();
`endif
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
